mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 65 ++++++
 rtl/mem_arbiter_tag_table.sv | 40 ++++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared bus command encoding, cache ownership and tag sizing
// for the icache/dcache memory arbiter.
package sys_defs;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_t;

  typedef enum logic {
    OWN_ICACHE = 1'b0,
    OWN_DCACHE = 1'b1
  } owner_t;

  localparam int TAG_W    = 4;
  localparam int NUM_TAGS = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache/memory side bundle of the arbiter: two requesters,
// one shared memory port and the routed returns.
interface mem_arbiter_if;
  import sys_defs::*;

  bus_cmd_t         icache2mem_command;
  logic [63:0]      icache2mem_addr;
  bus_cmd_t         dcache2mem_command;
  logic [63:0]      dcache2mem_addr;
  logic [63:0]      dcache2mem_data;
  logic [TAG_W-1:0] mem2proc_response;
  logic [63:0]      mem2proc_data;
  logic [TAG_W-1:0] mem2proc_tag;

  bus_cmd_t         proc2mem_command;
  logic [63:0]      proc2mem_addr;
  logic [63:0]      proc2mem_data;
  logic [TAG_W-1:0] mem2icache_response;
  logic [TAG_W-1:0] mem2icache_tag;
  logic [TAG_W-1:0] mem2dcache_response;
  logic [TAG_W-1:0] mem2dcache_tag;
  logic [63:0]      mem2cache_data;
  logic             tag_err;

  modport master (
    output icache2mem_command,
    output icache2mem_addr,
    output dcache2mem_command,
    output dcache2mem_addr,
    output dcache2mem_data,
    output mem2proc_response,
    output mem2proc_data,
    output mem2proc_tag,
    input  proc2mem_command,
    input  proc2mem_addr,
    input  proc2mem_data,
    input  mem2icache_response,
    input  mem2icache_tag,
    input  mem2dcache_response,
    input  mem2dcache_tag,
    input  mem2cache_data,
    input  tag_err
  );

  modport slave (
    input  icache2mem_command,
    input  icache2mem_addr,
    input  dcache2mem_command,
    input  dcache2mem_addr,
    input  dcache2mem_data,
    input  mem2proc_response,
    input  mem2proc_data,
    input  mem2proc_tag,
    output proc2mem_command,
    output proc2mem_addr,
    output proc2mem_data,
    output mem2icache_response,
    output mem2icache_tag,
    output mem2dcache_response,
    output mem2dcache_tag,
    output mem2cache_data,
    output tag_err
  );

endinterface

// File: rtl/mem_arbiter_tag_table.sv
// Outstanding-load ownership table: one allocate port and
// one lookup/clear port; allocation wins a same-tag clear.
module mem_tag_table
  import sys_defs::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  owner_t           alloc_owner,
  input  logic [TAG_W-1:0] look_tag,
  input  logic             clear_en,
  output logic             look_valid,
  output owner_t           look_owner
);

  logic [NUM_TAGS-1:0] valid;
  owner_t              owner [NUM_TAGS];

  always_comb begin
    look_valid = valid[look_tag];
    look_owner = owner[look_tag];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < NUM_TAGS; i++)
        owner[i] <= OWN_ICACHE;
    end else begin
      if (clear_en)
        valid[look_tag] <= 1'b0;
      if (alloc_en) begin
        valid[alloc_tag] <= 1'b1;
        owner[alloc_tag] <= alloc_owner;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between icache and dcache; dcache
// has priority until the icache has lost STARVE_LIMIT cycles.
module mem_arbiter
  import sys_defs::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_nxt;
  logic          i_req;
  logic          d_req;
  logic          grant_i;
  logic          grant_d;
  logic          accepted;
  bus_cmd_t      gnt_cmd;
  logic          alloc_en;
  owner_t        alloc_owner;
  logic          look_valid;
  owner_t        look_owner;
  logic          ret_any;
  logic          hit;
  logic          tag_err_q;

  always_comb begin
    i_req    = bus.icache2mem_command != BUS_NONE;
    d_req    = bus.dcache2mem_command != BUS_NONE;
    grant_i  = !reset && i_req
             && (!d_req || starve_cnt >= LIMIT);
    grant_d  = !reset && d_req && !grant_i;
    accepted = bus.mem2proc_response != '0;
  end

  always_comb begin
    gnt_cmd                 = BUS_NONE;
    bus.proc2mem_addr       = '0;
    bus.proc2mem_data       = '0;
    bus.mem2icache_response = '0;
    bus.mem2dcache_response = '0;
    unique case (1'b1)
      grant_i: begin
        gnt_cmd                 = bus.icache2mem_command;
        bus.proc2mem_addr       = bus.icache2mem_addr;
        bus.mem2icache_response = bus.mem2proc_response;
      end
      grant_d: begin
        gnt_cmd                 = bus.dcache2mem_command;
        bus.proc2mem_addr       = bus.dcache2mem_addr;
        bus.proc2mem_data       = bus.dcache2mem_data;
        bus.mem2dcache_response = bus.mem2proc_response;
      end
      default: ;
    endcase
    bus.proc2mem_command = gnt_cmd;
  end

  // Stores get no owner, so their returns surface as tag_err.
  always_comb begin
    alloc_en    = accepted && gnt_cmd == BUS_LOAD;
    alloc_owner = grant_i ? OWN_ICACHE : OWN_DCACHE;
  end

  mem_tag_table u_tbl (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_tag   (bus.mem2proc_response),
    .alloc_owner (alloc_owner),
    .look_tag    (bus.mem2proc_tag),
    .clear_en    (hit),
    .look_valid  (look_valid),
    .look_owner  (look_owner)
  );

  always_comb begin
    ret_any = !reset && bus.mem2proc_tag != '0;
    hit     = ret_any && look_valid;
    bus.mem2icache_tag = '0;
    bus.mem2dcache_tag = '0;
    if (hit && look_owner == OWN_ICACHE)
      bus.mem2icache_tag = bus.mem2proc_tag;
    if (hit && look_owner == OWN_DCACHE)
      bus.mem2dcache_tag = bus.mem2proc_tag;
    bus.mem2cache_data = bus.mem2proc_data;
    bus.tag_err        = tag_err_q;
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (!i_req)
      starve_nxt = '0;
    else if (grant_i && accepted)
      starve_nxt = '0;
    else if (!grant_i && starve_cnt < LIMIT)
      starve_nxt = starve_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
      tag_err_q  <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      if (ret_any && !look_valid)
        tag_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: grant/response vector table plus
// tag-return sequences checked against a return scoreboard.
module tb_mem_arbiter;
  import sys_defs::*;

  logic clock;
  logic reset;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total;
  int bad;

  typedef struct {
    logic [3:0] tag;
    owner_t     dest;
  } ret_t;

  ret_t sb [$];

  typedef struct {
    bus_cmd_t    ic;
    logic [63:0] ia;
    bus_cmd_t    dc;
    logic [63:0] da;
    logic [63:0] dd;
    logic [3:0]  rsp;
    bus_cmd_t    ecmd;
    logic [63:0] eaddr;
    logic [63:0] edata;
    logic [3:0]  eir;
    logic [3:0]  edr;
  } vec_t;

  vec_t vt [8];

  function automatic logic [63:0] mdata(input logic [3:0] r);
    return 64'hCAFE_F00D_0000_0000 | {60'h0, r};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bus_cmd_t ic, input logic [63:0] ia,
                       input bus_cmd_t dc, input logic [63:0] da,
                       input logic [63:0] dd, input logic [3:0] rsp,
                       input logic [3:0] tg);
    bus.icache2mem_command = ic;
    bus.icache2mem_addr    = ia;
    bus.dcache2mem_command = dc;
    bus.dcache2mem_addr    = da;
    bus.dcache2mem_data    = dd;
    bus.mem2proc_response  = rsp;
    bus.mem2proc_tag       = tg;
    bus.mem2proc_data      = mdata(rsp);
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic ret_next;
    ret_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: got none want entry");
    end else begin
      e = sb.pop_front();
      drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, e.tag);
      @(negedge clock);
      chk("ret_itag", 64'(bus.mem2icache_tag),
          64'(e.dest == OWN_ICACHE ? e.tag : 4'd0));
      chk("ret_dtag", 64'(bus.mem2dcache_tag),
          64'(e.dest == OWN_DCACHE ? e.tag : 4'd0));
      step();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vt[0] = '{BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0,
              BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0};
    vt[1] = '{BUS_LOAD, 64'h1000, BUS_NONE, 64'h0, 64'h0, 4'd1,
              BUS_LOAD, 64'h1000, 64'h0, 4'd1, 4'd0};
    vt[2] = '{BUS_NONE, 64'h0, BUS_LOAD, 64'h2000, 64'h55, 4'd2,
              BUS_LOAD, 64'h2000, 64'h55, 4'd0, 4'd2};
    vt[3] = '{BUS_NONE, 64'h0, BUS_STORE, 64'h3008, 64'hDEAD, 4'd0,
              BUS_STORE, 64'h3008, 64'hDEAD, 4'd0, 4'd0};
    vt[4] = '{BUS_LOAD, 64'h1010, BUS_STORE, 64'h3010, 64'hBEEF, 4'd6,
              BUS_STORE, 64'h3010, 64'hBEEF, 4'd0, 4'd6};
    vt[5] = '{BUS_LOAD, 64'h1018, BUS_NONE, 64'h0, 64'h0, 4'd0,
              BUS_LOAD, 64'h1018, 64'h0, 4'd0, 4'd0};
    vt[6] = '{BUS_LOAD, 64'h1020, BUS_LOAD, 64'h2020, 64'h77, 4'd0,
              BUS_LOAD, 64'h2020, 64'h77, 4'd0, 4'd0};
    vt[7] = '{BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd9,
              BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0};

    // reset state with live requests held on the inputs
    reset = 1'b1;
    drive(BUS_LOAD, 64'h8, BUS_LOAD, 64'h10, 64'h1, 4'd3, 4'd3);
    step();
    @(negedge clock);
    chk("rst_cmd", 64'(bus.proc2mem_command), 64'(BUS_NONE));
    chk("rst_iresp", 64'(bus.mem2icache_response), 64'h0);
    chk("rst_dresp", 64'(bus.mem2dcache_response), 64'h0);
    chk("rst_itag", 64'(bus.mem2icache_tag), 64'h0);
    chk("rst_dtag", 64'(bus.mem2dcache_tag), 64'h0);
    chk("rst_err", 64'(bus.tag_err), 64'h0);
    chk("rst_starve", 64'(dut.starve_cnt), 64'h0);
    step();
    reset = 1'b0;
    idle();

    for (int i = 0; i < 8; i++) begin
      drive(vt[i].ic, vt[i].ia, vt[i].dc, vt[i].da, vt[i].dd,
            vt[i].rsp, 4'd0);
      @(negedge clock);
      chk("v_cmd", 64'(bus.proc2mem_command), 64'(vt[i].ecmd));
      chk("v_addr", bus.proc2mem_addr, vt[i].eaddr);
      chk("v_data", bus.proc2mem_data, vt[i].edata);
      chk("v_iresp", 64'(bus.mem2icache_response), 64'(vt[i].eir));
      chk("v_dresp", 64'(bus.mem2dcache_response), 64'(vt[i].edr));
      chk("v_cdata", bus.mem2cache_data, mdata(vt[i].rsp));
      step();
    end

    // simultaneous loads: dcache wins, tag 3 routed back to it
    do_reset();
    drive(BUS_LOAD, 64'h100, BUS_LOAD, 64'h200, 64'h0, 4'd3, 4'd0);
    @(negedge clock);
    chk("both_addr", bus.proc2mem_addr, 64'h200);
    chk("both_dresp", 64'(bus.mem2dcache_response), 64'd3);
    chk("both_iresp", 64'(bus.mem2icache_response), 64'd0);
    sb.push_back('{4'd3, OWN_DCACHE});
    step();
    ret_next();
    chk("both_err", 64'(bus.tag_err), 64'h0);

    // starvation: icache wins on the fifth contested cycle
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(BUS_LOAD, 64'h4000, BUS_LOAD, 64'h5000 + 64'(8 * k),
            64'h0, 4'(k), 4'd0);
      @(negedge clock);
      chk("st_dresp", 64'(bus.mem2dcache_response), 64'(k));
      chk("st_iresp", 64'(bus.mem2icache_response), 64'd0);
      sb.push_back('{4'(k), OWN_DCACHE});
      step();
      chk("st_cnt", 64'(dut.starve_cnt), 64'(k));
    end
    drive(BUS_LOAD, 64'h4000, BUS_LOAD, 64'h5028, 64'h0, 4'd5, 4'd0);
    @(negedge clock);
    chk("st5_iresp", 64'(bus.mem2icache_response), 64'd5);
    chk("st5_dresp", 64'(bus.mem2dcache_response), 64'd0);
    chk("st5_addr", bus.proc2mem_addr, 64'h4000);
    sb.push_back('{4'd5, OWN_ICACHE});
    step();
    chk("st5_cnt", 64'(dut.starve_cnt), 64'd0);
    for (int k = 0; k < 5; k++)
      ret_next();

    // icache load tag 5 returns and its entry frees
    do_reset();
    drive(BUS_LOAD, 64'h6000, BUS_NONE, 64'h0, 64'h0, 4'd5, 4'd0);
    @(negedge clock);
    sb.push_back('{4'd5, OWN_ICACHE});
    step();
    chk("i5_valid_set", 64'(dut.u_tbl.valid[5]), 64'd1);
    ret_next();
    chk("i5_valid_clr", 64'(dut.u_tbl.valid[5]), 64'd0);
    chk("i5_err", 64'(bus.tag_err), 64'h0);

    // store tag 7 has no owner
    do_reset();
    drive(BUS_NONE, 64'h0, BUS_STORE, 64'h7000, 64'h1234, 4'd7, 4'd0);
    step();
    drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd7);
    @(negedge clock);
    chk("s7_itag", 64'(bus.mem2icache_tag), 64'd0);
    chk("s7_dtag", 64'(bus.mem2dcache_tag), 64'd0);
    step();
    chk("s7_err", 64'(bus.tag_err), 64'd1);

    // tag 2 returns to dcache while reallocated to icache
    do_reset();
    drive(BUS_NONE, 64'h0, BUS_LOAD, 64'h2200, 64'h0, 4'd2, 4'd0);
    @(negedge clock);
    sb.push_back('{4'd2, OWN_DCACHE});
    step();
    drive(BUS_LOAD, 64'h1200, BUS_NONE, 64'h0, 64'h0, 4'd2, 4'd2);
    @(negedge clock);
    chk("re_dtag", 64'(bus.mem2dcache_tag), 64'd2);
    chk("re_itag", 64'(bus.mem2icache_tag), 64'd0);
    void'(sb.pop_front());
    sb.push_back('{4'd2, OWN_ICACHE});
    step();
    chk("re_valid", 64'(dut.u_tbl.valid[2]), 64'd1);
    ret_next();
    chk("re_err", 64'(bus.tag_err), 64'h0);

    // reset with tags 1 and 4 outstanding
    do_reset();
    drive(BUS_LOAD, 64'h100, BUS_NONE, 64'h0, 64'h0, 4'd1, 4'd0);
    step();
    drive(BUS_NONE, 64'h0, BUS_LOAD, 64'h400, 64'h0, 4'd4, 4'd0);
    step();
    reset = 1'b1;
    drive(BUS_LOAD, 64'h100, BUS_LOAD, 64'h400, 64'h0, 4'd5, 4'd1);
    @(negedge clock);
    chk("mr_cmd", 64'(bus.proc2mem_command), 64'(BUS_NONE));
    chk("mr_iresp", 64'(bus.mem2icache_response), 64'd0);
    chk("mr_dresp", 64'(bus.mem2dcache_response), 64'd0);
    chk("mr_itag", 64'(bus.mem2icache_tag), 64'd0);
    chk("mr_dtag", 64'(bus.mem2dcache_tag), 64'd0);
    step();
    reset = 1'b0;
    sb.delete();
    idle();
    chk("mr_tbl", 64'(dut.u_tbl.valid), 64'h0);
    chk("mr_err0", 64'(bus.tag_err), 64'h0);
    drive(BUS_NONE, 64'h0, BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd4);
    @(negedge clock);
    chk("mr4_itag", 64'(bus.mem2icache_tag), 64'd0);
    chk("mr4_dtag", 64'(bus.mem2dcache_tag), 64'd0);
    step();
    chk("mr4_err", 64'(bus.tag_err), 64'd1);
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
